// File: rtl/cdb_arbiter_if.sv
// Producer and CDB signal bundle for the common data bus arbiter.
// The master side drives producer results and observes the broadcast.
// The slave side is the arbiter itself.
interface cdb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [31:0] alu_res;
    logic        alu_jump;
    logic [31:0] alu_jump_pc;
    logic [5:0]  alu_rob_index;

    logic        lsb_valid;
    logic        lsb_ready;
    logic [31:0] lsb_res;
    logic [5:0]  lsb_rob_index;

    logic        cdb_valid;
    logic        cdb_src;
    logic [31:0] cdb_res;
    logic        cdb_jump;
    logic [31:0] cdb_jump_pc;
    logic [5:0]  cdb_rob_index;

    modport master (
        output alu_valid, alu_res, alu_jump, alu_jump_pc, alu_rob_index,
        output lsb_valid, lsb_res, lsb_rob_index,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_src, cdb_res, cdb_jump, cdb_jump_pc, cdb_rob_index
    );

    modport slave (
        input  alu_valid, alu_res, alu_jump, alu_jump_pc, alu_rob_index,
        input  lsb_valid, lsb_res, lsb_rob_index,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_src, cdb_res, cdb_jump, cdb_jump_pc, cdb_rob_index
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per producer (ALU, LSB), drained
// round-robin one entry per cycle onto a registered broadcast bus.
// A flush or reset empties both FIFOs; a reset also clears the bus outputs.
module cdb_arbiter #(
    parameter int QDEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    logic [31:0]   alu_q_res [QDEPTH];
    logic          alu_q_jump [QDEPTH];
    logic [31:0]   alu_q_pc [QDEPTH];
    logic [5:0]    alu_q_idx [QDEPTH];
    logic [31:0]   lsb_q_res [QDEPTH];
    logic [5:0]    lsb_q_idx [QDEPTH];

    logic [PW-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
    logic [CW-1:0] alu_count, lsb_count;
    src_e          last_grant;

    logic          cdb_valid_q;
    logic          cdb_src_q;
    logic [31:0]   cdb_res_q;
    logic          cdb_jump_q;
    logic [31:0]   cdb_jump_pc_q;
    logic [5:0]    cdb_rob_index_q;

    logic          alu_ready_w, lsb_ready_w;
    logic          alu_push, lsb_push;
    logic          grant_alu, grant_lsb;

    // Ready looks only at registered counts, so a full queue stays not-ready
    // even in a cycle where its head is being broadcast.
    assign alu_ready_w = rdy && rst && !flush && (alu_count < FULL);
    assign lsb_ready_w = rdy && rst && !flush && (lsb_count < FULL);
    assign alu_push    = bus.alu_valid && alu_ready_w;
    assign lsb_push    = bus.lsb_valid && lsb_ready_w;

    // On a tie the producer that did not win last time gets the bus.
    assign grant_alu = (alu_count != '0) && ((lsb_count == '0) || (last_grant == SRC_LSB));
    assign grant_lsb = (lsb_count != '0) && ((alu_count == '0) || (last_grant == SRC_ALU));

    assign bus.alu_ready     = alu_ready_w;
    assign bus.lsb_ready     = lsb_ready_w;
    assign bus.cdb_valid     = cdb_valid_q;
    assign bus.cdb_src       = cdb_src_q;
    assign bus.cdb_res       = cdb_res_q;
    assign bus.cdb_jump      = cdb_jump_q;
    assign bus.cdb_jump_pc   = cdb_jump_pc_q;
    assign bus.cdb_rob_index = cdb_rob_index_q;

    // FIFO payload storage; pushes are already qualified by reset, stall and flush.
    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_q_res[alu_tail]  <= bus.alu_res;
            alu_q_jump[alu_tail] <= bus.alu_jump;
            alu_q_pc[alu_tail]   <= bus.alu_jump_pc;
            alu_q_idx[alu_tail]  <= bus.alu_rob_index;
        end
        if (lsb_push) begin
            lsb_q_res[lsb_tail] <= bus.lsb_res;
            lsb_q_idx[lsb_tail] <= bus.lsb_rob_index;
        end
    end

    // Queue pointers, counts, round-robin state and the registered broadcast.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_head        <= '0;
            alu_tail        <= '0;
            alu_count       <= '0;
            lsb_head        <= '0;
            lsb_tail        <= '0;
            lsb_count       <= '0;
            last_grant      <= SRC_LSB;
            cdb_valid_q     <= 1'b0;
            cdb_src_q       <= 1'b0;
            cdb_res_q       <= '0;
            cdb_jump_q      <= 1'b0;
            cdb_jump_pc_q   <= '0;
            cdb_rob_index_q <= '0;
        end else if (rdy) begin
            if (flush) begin
                alu_head    <= '0;
                alu_tail    <= '0;
                alu_count   <= '0;
                lsb_head    <= '0;
                lsb_tail    <= '0;
                lsb_count   <= '0;
                last_grant  <= SRC_LSB;
                cdb_valid_q <= 1'b0;
            end else begin
                if (alu_push)  alu_tail <= alu_tail + PW'(1);
                if (grant_alu) alu_head <= alu_head + PW'(1);
                if (lsb_push)  lsb_tail <= lsb_tail + PW'(1);
                if (grant_lsb) lsb_head <= lsb_head + PW'(1);

                case ({alu_push, grant_alu})
                    2'b10:   alu_count <= alu_count + CW'(1);
                    2'b01:   alu_count <= alu_count - CW'(1);
                    default: alu_count <= alu_count;
                endcase
                case ({lsb_push, grant_lsb})
                    2'b10:   lsb_count <= lsb_count + CW'(1);
                    2'b01:   lsb_count <= lsb_count - CW'(1);
                    default: lsb_count <= lsb_count;
                endcase

                if (grant_alu) begin
                    cdb_valid_q     <= 1'b1;
                    cdb_src_q       <= SRC_ALU;
                    cdb_res_q       <= alu_q_res[alu_head];
                    cdb_jump_q      <= alu_q_jump[alu_head];
                    cdb_jump_pc_q   <= alu_q_pc[alu_head];
                    cdb_rob_index_q <= alu_q_idx[alu_head];
                    last_grant      <= SRC_ALU;
                end else if (grant_lsb) begin
                    cdb_valid_q     <= 1'b1;
                    cdb_src_q       <= SRC_LSB;
                    cdb_res_q       <= lsb_q_res[lsb_head];
                    cdb_jump_q      <= 1'b0;
                    cdb_jump_pc_q   <= '0;
                    cdb_rob_index_q <= lsb_q_idx[lsb_head];
                    last_grant      <= SRC_LSB;
                end else begin
                    cdb_valid_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (QDEPTH=2).
// Accepted pushes are queued per producer as expected beats; every new
// broadcast is recorded and matched against the head of its producer queue.
module tb_cdb_arbiter;
    typedef struct packed {
        logic        src;
        logic [31:0] res;
        logic        jump;
        logic [31:0] pc;
        logic [5:0]  idx;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;

    cdb_arbiter_if bus();

    cdb_arbiter #(.QDEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    beat_t exp_alu[$];
    beat_t exp_lsb[$];
    beat_t obs_beat[$];
    int    obs_cyc[$];

    function automatic beat_t cur_beat();
        return {bus.cdb_src, bus.cdb_res, bus.cdb_jump, bus.cdb_jump_pc, bus.cdb_rob_index};
    endfunction

    function automatic beat_t pop_exp(logic src);
        if (src == 1'b0 && exp_alu.size() > 0) return exp_alu.pop_front();
        if (src == 1'b1 && exp_lsb.size() > 0) return exp_lsb.pop_front();
        return '1;
    endfunction

    task automatic set_alu(logic v, logic [5:0] idx, logic [31:0] res, logic j, logic [31:0] pc);
        bus.alu_valid     = v;
        bus.alu_rob_index = idx;
        bus.alu_res       = res;
        bus.alu_jump      = j;
        bus.alu_jump_pc   = pc;
    endtask

    task automatic set_lsb(logic v, logic [5:0] idx, logic [31:0] res);
        bus.lsb_valid     = v;
        bus.lsb_rob_index = idx;
        bus.lsb_res       = res;
    endtask

    // One clock: note accepted pushes, advance, record any new broadcast.
    task automatic cycle(output logic a_acc, output logic l_acc);
        logic edge_live;
        #1;
        a_acc = bus.alu_valid && bus.alu_ready;
        l_acc = bus.lsb_valid && bus.lsb_ready;
        if (a_acc) exp_alu.push_back({1'b0, bus.alu_res, bus.alu_jump, bus.alu_jump_pc, bus.alu_rob_index});
        if (l_acc) exp_lsb.push_back({1'b1, bus.lsb_res, 1'b0, 32'h0, bus.lsb_rob_index});
        edge_live = rdy && rst;
        @(posedge clk);
        #1;
        cyc++;
        if (edge_live && bus.cdb_valid === 1'b1) begin
            obs_beat.push_back(cur_beat());
            obs_cyc.push_back(cyc);
        end
    endtask

    task automatic idle(int n);
        logic a, l;
        set_alu(1'b0, 6'h0, 32'h0, 1'b0, 32'h0);
        set_lsb(1'b0, 6'h0, 32'h0);
        repeat (n) cycle(a, l);
    endtask

    task automatic do_reset();
        logic a, l;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        set_alu(1'b0, 6'h0, 32'h0, 1'b0, 32'h0);
        set_lsb(1'b0, 6'h0, 32'h0);
        cycle(a, l);
        rst = 1'b1;
        exp_alu.delete(); exp_lsb.delete(); obs_beat.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset();
        logic a, l;
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        set_alu(1'b1, 6'd33, 32'hAAAA_0000, 1'b1, 32'h4444);
        set_lsb(1'b1, 6'd34, 32'hBBBB_0000);
        cycle(a, l);
        checks++; if ({a, l} !== 2'b00) $display("[TB] FAIL reset_accept: got %b want 00", {a, l}); else passed++;
        checks++; if (cur_beat() !== beat_t'(0)) $display("[TB] FAIL reset_bus: got %h want 0", cur_beat()); else passed++;
        checks++; if (bus.cdb_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", bus.cdb_valid); else passed++;
        checks++; if ({bus.alu_ready, bus.lsb_ready} !== 2'b00) $display("[TB] FAIL reset_ready_low: got %b want 00", {bus.alu_ready, bus.lsb_ready}); else passed++;
        rst = 1'b1;
        set_alu(1'b0, 6'h0, 32'h0, 1'b0, 32'h0);
        set_lsb(1'b0, 6'h0, 32'h0);
        #1;
        checks++; if ({bus.alu_ready, bus.lsb_ready} !== 2'b11) $display("[TB] FAIL reset_ready_high: got %b want 11", {bus.alu_ready, bus.lsb_ready}); else passed++;
        exp_alu.delete(); exp_lsb.delete();
        idle(3);
        checks++; if (obs_beat.size() !== 0) $display("[TB] FAIL reset_no_beat: got %0d beats want 0", obs_beat.size()); else passed++;
        obs_beat.delete(); obs_cyc.delete();
    endtask

    task automatic test_alu_only();
        logic a, l;
        int push_cyc;
        beat_t got[$];
        int gcyc[$];
        beat_t e;
        do_reset();
        set_alu(1'b1, 6'd3, 32'h10, 1'b0, 32'h0);
        cycle(a, l);
        push_cyc = cyc;
        set_alu(1'b1, 6'd4, 32'h20, 1'b0, 32'h0);
        cycle(a, l);
        idle(4);
        got = obs_beat; gcyc = obs_cyc; obs_beat.delete(); obs_cyc.delete();
        checks++; if (got.size() !== 2) $display("[TB] FAIL alu_beats: got %0d want 2", got.size()); else passed++;
        while (got.size() < 2) begin got.push_back('x); gcyc.push_back(-1); end
        for (int i = 0; i < 2; i++) begin
            e = pop_exp(got[i].src);
            checks++; if (got[i] !== e) $display("[TB] FAIL alu_beat%0d: got %h want %h", i, got[i], e); else passed++;
        end
        checks++; if (got[0].idx !== 6'd3 || got[1].idx !== 6'd4) $display("[TB] FAIL alu_order: got %0d,%0d want 3,4", got[0].idx, got[1].idx); else passed++;
        checks++; if (gcyc[0] !== push_cyc + 1) $display("[TB] FAIL alu_latency: got cycle %0d want %0d", gcyc[0], push_cyc + 1); else passed++;
        checks++; if (gcyc[1] !== gcyc[0] + 1) $display("[TB] FAIL alu_back_to_back: got cycle %0d want %0d", gcyc[1], gcyc[0] + 1); else passed++;
    endtask

    task automatic test_tie();
        logic a, l;
        int ai, li;
        beat_t got[$];
        beat_t e;
        logic [5:0] want_idx [6];
        want_idx = '{6'd1, 6'd9, 6'd2, 6'd10, 6'd3, 6'd11};
        do_reset();
        ai = 0; li = 0;
        for (int c = 0; c < 20 && (ai < 3 || li < 3); c++) begin
            set_alu(ai < 3, 6'(1 + ai), 32'h100 + 32'(ai), 1'b1, 32'h2000 + 32'(ai));
            set_lsb(li < 3, 6'(9 + li), 32'h500 + 32'(li));
            cycle(a, l);
            if (a) ai++;
            if (l) li++;
        end
        idle(6);
        checks++; if (ai !== 3 || li !== 3) $display("[TB] FAIL tie_pushes: got %0d/%0d want 3/3", ai, li); else passed++;
        got = obs_beat; obs_beat.delete(); obs_cyc.delete();
        checks++; if (got.size() !== 6) $display("[TB] FAIL tie_beats: got %0d want 6", got.size()); else passed++;
        while (got.size() < 6) got.push_back('x);
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i].idx !== want_idx[i]) $display("[TB] FAIL tie_order%0d: got %0d want %0d", i, got[i].idx, want_idx[i]); else passed++;
            e = pop_exp(got[i].src);
            checks++; if (got[i] !== e) $display("[TB] FAIL tie_beat%0d: got %h want %h", i, got[i], e); else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic a, l, popped, saw_full;
        int ai, li, lc, nb, lsb_beats;
        beat_t got[$];
        beat_t e;
        do_reset();
        ai = 0; li = 0; lc = 0; saw_full = 1'b0;
        for (int c = 0; c < 40 && (ai < 6 || li < 3); c++) begin
            set_alu(ai < 6, 6'(20 + ai), 32'h3000 + 32'(ai), 1'b0, 32'h0);
            set_lsb(li < 3, 6'(5 + li), 32'h7700 + 32'(li));
            nb = obs_beat.size();
            cycle(a, l);
            if (a) ai++;
            if (l) li++;
            popped = (obs_beat.size() > nb) && (obs_beat[obs_beat.size() - 1].src == 1'b1);
            lc = lc + int'(l) - int'(popped);
            if (lc == 2) saw_full = 1'b1;
            checks++; if (bus.lsb_ready !== (lc < 2)) $display("[TB] FAIL bp_lsb_ready: got %b want %b (lsb held %0d)", bus.lsb_ready, lc < 2, lc); else passed++;
        end
        idle(10);
        checks++; if (saw_full !== 1'b1) $display("[TB] FAIL bp_full_seen: got %b want 1", saw_full); else passed++;
        checks++; if (ai !== 6 || li !== 3) $display("[TB] FAIL bp_pushes: got %0d/%0d want 6/3", ai, li); else passed++;
        got = obs_beat; obs_beat.delete(); obs_cyc.delete();
        lsb_beats = 0;
        foreach (got[i]) begin
            if (got[i].src == 1'b1) lsb_beats++;
            e = pop_exp(got[i].src);
            checks++; if (got[i] !== e) $display("[TB] FAIL bp_beat%0d: got %h want %h", i, got[i], e); else passed++;
        end
        checks++; if (lsb_beats !== 3) $display("[TB] FAIL bp_lsb_count: got %0d want 3", lsb_beats); else passed++;
        checks++; if (exp_alu.size() + exp_lsb.size() !== 0) $display("[TB] FAIL bp_lost: got %0d pending want 0", exp_alu.size() + exp_lsb.size()); else passed++;
    endtask

    task automatic test_branch();
        logic a, l;
        beat_t got[$];
        beat_t e;
        do_reset();
        set_alu(1'b1, 6'd7, 32'hCAFE_0007, 1'b1, 32'h1000);
        cycle(a, l);
        idle(3);
        got = obs_beat; obs_beat.delete(); obs_cyc.delete();
        checks++; if (got.size() !== 1) $display("[TB] FAIL br_beats: got %0d want 1", got.size()); else passed++;
        if (got.size() == 0) got.push_back('x);
        checks++; if ({got[0].jump, got[0].pc} !== {1'b1, 32'h1000}) $display("[TB] FAIL br_jump: got %b/%h want 1/00001000", got[0].jump, got[0].pc); else passed++;
        checks++; if ({got[0].res, got[0].idx} !== {32'hCAFE_0007, 6'd7}) $display("[TB] FAIL br_res: got %h/%0d want cafe0007/7", got[0].res, got[0].idx); else passed++;
        e = pop_exp(got[0].src);
        checks++; if (got[0] !== e) $display("[TB] FAIL br_beat: got %h want %h", got[0], e); else passed++;
    endtask

    task automatic test_flush();
        logic a, l;
        int push_cyc;
        beat_t got[$];
        int gcyc[$];
        beat_t e;
        do_reset();
        set_alu(1'b1, 6'd30, 32'h30, 1'b0, 32'h0);
        set_lsb(1'b1, 6'd40, 32'h40);
        cycle(a, l);
        set_alu(1'b1, 6'd31, 32'h31, 1'b0, 32'h0);
        set_lsb(1'b1, 6'd41, 32'h41);
        cycle(a, l);
        got = obs_beat; obs_beat.delete(); obs_cyc.delete();
        checks++; if (got.size() !== 1) $display("[TB] FAIL fl_pre_beats: got %0d want 1", got.size()); else passed++;
        if (got.size() == 0) got.push_back('x);
        e = pop_exp(got[0].src);
        checks++; if (got[0] !== e || got[0].idx !== 6'd30) $display("[TB] FAIL fl_pre_beat: got %h want %h", got[0], e); else passed++;
        flush = 1'b1;
        set_alu(1'b1, 6'd32, 32'h32, 1'b0, 32'h0);
        set_lsb(1'b1, 6'd42, 32'h42);
        #1;
        checks++; if ({bus.alu_ready, bus.lsb_ready} !== 2'b00) $display("[TB] FAIL fl_ready: got %b want 00", {bus.alu_ready, bus.lsb_ready}); else passed++;
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_index !== 6'd30) $display("[TB] FAIL fl_same_cycle: got %b/%0d want 1/30", bus.cdb_valid, bus.cdb_rob_index); else passed++;
        cycle(a, l);
        checks++; if ({a, l} !== 2'b00) $display("[TB] FAIL fl_drop: got %b want 00", {a, l}); else passed++;
        flush = 1'b0;
        checks++; if (bus.cdb_valid !== 1'b0) $display("[TB] FAIL fl_valid: got %b want 0", bus.cdb_valid); else passed++;
        exp_alu.delete(); exp_lsb.delete();
        idle(5);
        checks++; if (obs_beat.size() !== 0) $display("[TB] FAIL fl_stale: got %0d beats want 0", obs_beat.size()); else passed++;
        obs_beat.delete(); obs_cyc.delete();
        set_lsb(1'b1, 6'd12, 32'h1212);
        cycle(a, l);
        push_cyc = cyc;
        idle(3);
        got = obs_beat; gcyc = obs_cyc; obs_beat.delete(); obs_cyc.delete();
        checks++; if (got.size() !== 1) $display("[TB] FAIL fl_fresh_beats: got %0d want 1", got.size()); else passed++;
        if (got.size() == 0) begin got.push_back('x); gcyc.push_back(-1); end
        e = pop_exp(got[0].src);
        checks++; if (got[0] !== e || got[0].idx !== 6'd12) $display("[TB] FAIL fl_fresh: got %h want %h", got[0], e); else passed++;
        checks++; if (gcyc[0] !== push_cyc + 1) $display("[TB] FAIL fl_fresh_latency: got cycle %0d want %0d", gcyc[0], push_cyc + 1); else passed++;
    endtask

    task automatic test_stall_reset();
        logic a, l;
        beat_t got[$];
        beat_t e50, e;
        do_reset();
        set_alu(1'b1, 6'd50, 32'h5050, 1'b1, 32'h50A0);
        cycle(a, l);
        set_alu(1'b1, 6'd51, 32'h5151, 1'b0, 32'h0);
        cycle(a, l);
        got = obs_beat; obs_beat.delete(); obs_cyc.delete();
        if (got.size() == 0) got.push_back('x);
        e50 = pop_exp(got[0].src);
        checks++; if (got[0] !== e50 || got[0].idx !== 6'd50) $display("[TB] FAIL st_first: got %h want %h", got[0], e50); else passed++;
        rdy = 1'b0;
        set_alu(1'b1, 6'd60, 32'h6060, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(a, l);
            checks++; if (bus.cdb_valid !== 1'b1 || cur_beat() !== e50) $display("[TB] FAIL st_hold%0d: got %b/%h want 1/%h", i, bus.cdb_valid, cur_beat(), e50); else passed++;
            checks++; if ({a, l, bus.alu_ready, bus.lsb_ready} !== 4'b0000) $display("[TB] FAIL st_ready%0d: got %b want 0000", i, {a, l, bus.alu_ready, bus.lsb_ready}); else passed++;
        end
        rdy = 1'b1;
        set_alu(1'b1, 6'd52, 32'h5252, 1'b0, 32'h0);
        cycle(a, l);
        got = obs_beat; obs_beat.delete(); obs_cyc.delete();
        if (got.size() == 0) got.push_back('x);
        e = pop_exp(got[0].src);
        checks++; if (got[0] !== e || got[0].idx !== 6'd51) $display("[TB] FAIL st_resume: got %h want %h", got[0], e); else passed++;
        rst = 1'b0;
        rdy = 1'b0;
        set_alu(1'b0, 6'h0, 32'h0, 1'b0, 32'h0);
        cycle(a, l);
        checks++; if (bus.cdb_valid !== 1'b0 || cur_beat() !== beat_t'(0)) $display("[TB] FAIL st_reset_bus: got %b/%h want 0/0", bus.cdb_valid, cur_beat()); else passed++;
        checks++; if ({bus.alu_ready, bus.lsb_ready} !== 2'b00) $display("[TB] FAIL st_reset_ready: got %b want 00", {bus.alu_ready, bus.lsb_ready}); else passed++;
        rst = 1'b1;
        rdy = 1'b1;
        exp_alu.delete(); exp_lsb.delete(); obs_beat.delete(); obs_cyc.delete();
        idle(4);
        checks++; if (obs_beat.size() !== 0) $display("[TB] FAIL st_discard: got %0d beats want 0", obs_beat.size()); else passed++;
        checks++; if ({bus.alu_ready, bus.lsb_ready} !== 2'b11) $display("[TB] FAIL st_empty_ready: got %b want 11", {bus.alu_ready, bus.lsb_ready}); else passed++;
    endtask

    // Hard stop if anything ever waits far longer than the tests need.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        flush = 1'b0;
        set_alu(1'b0, 6'h0, 32'h0, 1'b0, 32'h0);
        set_lsb(1'b0, 6'h0, 32'h0);
        @(posedge clk);
        #1;
        test_reset();
        test_alu_only();
        test_tie();
        test_backpressure();
        test_branch();
        test_flush();
        test_stall_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
